sram_sprite_fetcher: RTL

Parametrised pixel fetch engine for packed sprite/background images in external SRAM.
- Holds a runtime-writable region table: base address, width and height per region.
- On a start command it scans a row range of one region in raster order and issues SRAM word reads. It unpacks PIX_W-bit pixels and streams them to the renderer with valid/ready.
- Sits between the SRAM arbiter and the VGA compositor.
- Generalises the fixed map/player/bullet/caption layout to any pixel width and region count.

---
 rtl/sprite_fetch_pkg.sv | 39 +++
 rtl/sprite_pixel_unpack.sv | 23 ++
 rtl/sram_sprite_fetcher.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_fetch_pkg.sv
// Shared types for the SRAM sprite fetcher: FSM states, region table entry and lane helpers.
package sprite_fetch_pkg;

    localparam int unsigned CFG_ADDR_W = 20;
    localparam int unsigned CFG_DIM_W  = 11;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StReq,
        StWait,
        StEmit,
        StDone
    } fetch_state_e;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] base;
        logic [CFG_DIM_W-1:0]  width;
        logic [CFG_DIM_W-1:0]  height;
    } region_cfg_t;

    function automatic int unsigned ppw_log2(input int unsigned data_w, input int unsigned pix_w);
        return $clog2(data_w / pix_w);
    endfunction

    // Default slot assignment used by the game firmware
    localparam int unsigned REGION_MAP           = 0;
    localparam int unsigned REGION_PLAYER1       = 1;
    localparam int unsigned REGION_PLAYER1_SQUAT = 2;
    localparam int unsigned REGION_PLAYER2       = 3;
    localparam int unsigned REGION_PLAYER2_SQUAT = 4;
    localparam int unsigned REGION_BULLET1       = 5;
    localparam int unsigned REGION_BULLET2       = 6;
    localparam int unsigned REGION_WIN_CAPTION   = 7;
    localparam int unsigned REGION_LOSE_CAPTION  = 8;
    localparam int unsigned REGION_IDLE_BG       = 9;
    localparam int unsigned REGION_START_CAPTION = 10;

endpackage

// File: rtl/sprite_pixel_unpack.sv
// Selects one PIX_W-bit pixel out of a packed SRAM word; lane 0 is the most significant field.
module sprite_pixel_unpack #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned LANE_W = 2
) (
    input  logic [DATA_W-1:0] word,
    input  logic [LANE_W-1:0] lane,
    output logic [PIX_W-1:0]  pix
);

    localparam int unsigned PPW = DATA_W / PIX_W;

    always_comb begin
        pix = '0;
        for (int unsigned i = 0; i < PPW; i++) begin
            if ((32'(lane) % PPW) == i) begin
                pix = word[DATA_W-1-i*PIX_W -: PIX_W];
            end
        end
    end

endmodule

// File: rtl/sram_sprite_fetcher.sv
// Region-table driven raster pixel fetcher between the SRAM arbiter and the compositor.
// Define SPRITE_FETCH_MIRROR_EN to enable per-fetch horizontal mirroring via i_mirror.
module sram_sprite_fetcher
    import sprite_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PIX_W       = 4,
    parameter int unsigned NUM_REGIONS = 16,
    parameter int unsigned DIM_W       = 11
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_cfg_we,
    input  logic [$clog2(NUM_REGIONS)-1:0] i_cfg_region,
    input  logic [ADDR_W-1:0]              i_cfg_base,
    input  logic [DIM_W-1:0]               i_cfg_width,
    input  logic [DIM_W-1:0]               i_cfg_height,
    output logic                           o_cfg_drop,
    input  logic                           i_start,
    input  logic [$clog2(NUM_REGIONS)-1:0] i_region,
    input  logic [DIM_W-1:0]               i_row_first,
    input  logic [DIM_W-1:0]               i_row_cnt,
    input  logic                           i_mirror,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic                           o_sram_req,
    output logic [ADDR_W-1:0]              o_sram_addr,
    input  logic                           i_sram_gnt,
    input  logic                           i_sram_rvalid,
    input  logic [DATA_W-1:0]              i_sram_rdata,
    output logic                           o_pix_valid,
    output logic [PIX_W-1:0]               o_pix,
    output logic                           o_pix_eol,
    output logic                           o_pix_last,
    input  logic                           i_pix_ready
);

    localparam int unsigned PPW_LOG2 = ppw_log2(DATA_W, PIX_W);
    localparam int unsigned LANE_W   = (PPW_LOG2 > 0) ? PPW_LOG2 : 1;
    localparam int unsigned IDX_W    = ADDR_W + PPW_LOG2;

    region_cfg_t tbl_q [NUM_REGIONS];

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [DIM_W-1:0]   width_q, height_q, row_first_q, row_cnt_q, rows_left_q, col_q;
    logic [IDX_W-1:0]   row_base_q;
    logic [LANE_W-1:0]  lane_q;
    logic [DATA_W-1:0]  cache_word_q;
    logic [ADDR_W-1:0]  cache_addr_q, sram_addr_q;
    logic               cache_valid_q, err_q, cfg_drop_q;
    logic               mirror;

`ifdef SPRITE_FETCH_MIRROR_EN
    logic mirror_q;
    assign mirror = mirror_q;
`else
    logic unused_mirror;
    assign mirror        = 1'b0;
    assign unused_mirror = i_mirror;
`endif

    logic [IDX_W-1:0]  row_prod, setup_idx, next_row_base, next_idx;
    logic [DIM_W-1:0]  eff_rows, col_first, next_col;
    logic [ADDR_W-1:0] setup_addr, next_addr;
    logic              end_of_row, last_pix, region_ok;

    always_comb begin
        row_prod  = IDX_W'(row_first_q) * IDX_W'(width_q);
        col_first = mirror ? width_q - 1'b1 : '0;
        setup_idx = row_prod + IDX_W'(col_first);
        if (row_first_q >= height_q) begin
            eff_rows = '0;
        end else if (row_cnt_q < height_q - row_first_q) begin
            eff_rows = row_cnt_q;
        end else begin
            eff_rows = height_q - row_first_q;
        end
        end_of_row    = mirror ? (col_q == '0) : (col_q == width_q - 1'b1);
        last_pix      = end_of_row && (rows_left_q == DIM_W'(1));
        next_row_base = end_of_row ? row_base_q + IDX_W'(width_q) : row_base_q;
        if (end_of_row) begin
            next_col = col_first;
        end else if (mirror) begin
            next_col = col_q - 1'b1;
        end else begin
            next_col = col_q + 1'b1;
        end
        next_idx   = next_row_base + IDX_W'(next_col);
        // Word address wraps modulo 2^ADDR_W
        setup_addr = base_q + ADDR_W'(setup_idx >> PPW_LOG2);
        next_addr  = base_q + ADDR_W'(next_idx >> PPW_LOG2);
        region_ok  = 32'(i_region) < NUM_REGIONS;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            base_q        <= '0;
            width_q       <= '0;
            height_q      <= '0;
            row_first_q   <= '0;
            row_cnt_q     <= '0;
            rows_left_q   <= '0;
            col_q         <= '0;
            row_base_q    <= '0;
            lane_q        <= '0;
            cache_word_q  <= '0;
            cache_addr_q  <= '0;
            cache_valid_q <= 1'b0;
            sram_addr_q   <= '0;
            err_q         <= 1'b0;
            cfg_drop_q    <= 1'b0;
`ifdef SPRITE_FETCH_MIRROR_EN
            mirror_q      <= 1'b0;
`endif
            for (int i = 0; i < int'(NUM_REGIONS); i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            err_q      <= 1'b0;
            cfg_drop_q <= 1'b0;
            if (i_cfg_we) begin
                if (state_q != StIdle) begin
                    cfg_drop_q <= 1'b1;
                end else if (32'(i_cfg_region) < NUM_REGIONS) begin
                    tbl_q[i_cfg_region] <= '{base:   CFG_ADDR_W'(i_cfg_base),
                                             width:  CFG_DIM_W'(i_cfg_width),
                                             height: CFG_DIM_W'(i_cfg_height)};
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        if (!region_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q      <= ADDR_W'(tbl_q[i_region].base);
                            width_q     <= DIM_W'(tbl_q[i_region].width);
                            height_q    <= DIM_W'(tbl_q[i_region].height);
                            row_first_q <= i_row_first;
                            row_cnt_q   <= i_row_cnt;
`ifdef SPRITE_FETCH_MIRROR_EN
                            mirror_q    <= i_mirror;
`endif
                            state_q     <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    if (eff_rows == '0 || width_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        row_base_q  <= row_prod;
                        col_q       <= col_first;
                        lane_q      <= setup_idx[LANE_W-1:0];
                        rows_left_q <= eff_rows;
                        sram_addr_q <= setup_addr;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (i_sram_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (i_sram_rvalid) begin
                        cache_word_q  <= i_sram_rdata;
                        cache_addr_q  <= sram_addr_q;
                        cache_valid_q <= 1'b1;
                        state_q       <= StEmit;
                    end
                end
                StEmit: begin
                    if (i_pix_ready) begin
                        if (last_pix) begin
                            state_q <= StDone;
                        end else begin
                            col_q      <= next_col;
                            row_base_q <= next_row_base;
                            lane_q     <= next_idx[LANE_W-1:0];
                            if (end_of_row) begin
                                rows_left_q <= rows_left_q - 1'b1;
                            end
                            // Only fetch again when the next pixel lives in a different word
                            if (!(cache_valid_q && next_addr == cache_addr_q)) begin
                                sram_addr_q <= next_addr;
                                state_q     <= StReq;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    logic [PIX_W-1:0] lane_pix;

    sprite_pixel_unpack #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .LANE_W (LANE_W)
    ) u_unpack (
        .word (cache_word_q),
        .lane (lane_q),
        .pix  (lane_pix)
    );

    assign o_busy      = state_q != StIdle;
    assign o_done      = state_q == StDone;
    assign o_err       = err_q;
    assign o_cfg_drop  = cfg_drop_q;
    assign o_sram_req  = state_q == StReq;
    assign o_sram_addr = sram_addr_q;
    assign o_pix_valid = state_q == StEmit;
    assign o_pix       = o_pix_valid ? lane_pix : '0;
    assign o_pix_eol   = o_pix_valid && end_of_row;
    assign o_pix_last  = o_pix_valid && last_pix;

endmodule
